relu_pool_buffer: RTL and testbench

RELU_POOL_BUFFER -- requirements
Module: relu_pool_buffer

---
 rtl/relu_pool_if.sv | 27 ++
 rtl/relu_pool_buffer.sv | 92 +++++++++
 tb/tb_relu_pool_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/relu_pool_if.sv
// Handshake bundle between the relu producer, the pooling buffer and its consumer.
// The slave modport is the buffer's view of the bundle; the master modport is the environment's view.
interface relu_pool_if #(
   parameter int channel = 10,
   parameter int width   = 4,
   parameter int depth   = 4
) ();
   localparam int count_w = $clog2(depth + 1);

   logic                       in_valid;
   logic [channel*width-1:0]   in_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [channel*width-1:0]   out_data;
   logic [count_w-1:0]         fifo_count;
   logic                       overflow;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, fifo_count, overflow
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, fifo_count, overflow
   );
endinterface

// File: rtl/relu_pool_buffer.sv
// Max-pools every `pool` relu result vectors per channel and queues the pooled
// vectors in a first-word-fall-through FIFO with a sticky overflow flag.
module relu_pool_buffer #(
   parameter int channel = 10,
   parameter int width   = 4,
   parameter int pool    = 2,
   parameter int depth   = 4
) (
   input  logic        clk,
   input  logic        rst,
   relu_pool_if.slave  bus
);
   localparam int dw      = channel * width;
   localparam int ptr_w   = $clog2(depth);
   localparam int cnt_w   = (pool > 1) ? $clog2(pool) : 1;
   localparam int count_w = $clog2(depth + 1);

   logic [cnt_w-1:0]   cnt;
   logic [dw-1:0]      acc;
   logic [dw-1:0]      pooled;
   logic [dw-1:0]      mem [depth];
   logic [ptr_w-1:0]   rd_ptr;
   logic [ptr_w-1:0]   wr_ptr;
   logic [count_w-1:0] count;
   logic               ovf_q;

   logic win_last;
   logic full;
   logic push;
   logic pop;
   logic push_ok;

   assign win_last = (cnt == cnt_w'(pool - 1));
   assign full     = (count == count_w'(depth));
   assign push     = bus.in_valid && win_last;
   assign pop      = (count != '0) && bus.out_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok  = push && (!full || pop);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pooled = bus.in_data;
      if (cnt != '0) begin
         for (int i = 0; i < channel; i++) begin
            if (acc[width*i +: width] > bus.in_data[width*i +: width])
               pooled[width*i +: width] = acc[width*i +: width];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
         acc <= '0;
      end else if (bus.in_valid) begin
         acc <= pooled;
         cnt <= win_last ? '0 : cnt + cnt_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + ptr_w'(1);
         if (push_ok)
            wr_ptr <= wr_ptr + ptr_w'(1);
         if (push && full && !pop)
            ovf_q <= 1'b1;
         if (push_ok && !pop)
            count <= count + count_w'(1);
         else if (pop && !push_ok)
            count <= count - count_w'(1);
      end
   end

   // NOTE: the storage array is not reset; the zero-gated read below hides stale entries.
   always_ff @(posedge clk) begin
      if (rst && push_ok)
         mem[wr_ptr] <= pooled;
   end

   assign bus.out_valid  = (count != '0);
   assign bus.out_data   = (count != '0) ? mem[rd_ptr] : '0;
   assign bus.fifo_count = count;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_relu_pool_buffer.sv
// Self-checking bench for relu_pool_buffer: vector table, directed corner sequences
// and randomized traffic, all compared against a queue-based pooling model.
module tb_relu_pool_buffer;
   localparam int CH    = 10;
   localparam int W     = 4;
   localparam int POOL  = 2;
   localparam int DEPTH = 4;
   localparam int DW    = CH * W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   relu_pool_if #(.channel(CH), .width(W), .depth(DEPTH)) bus ();

   relu_pool_buffer #(.channel(CH), .width(W), .pool(POOL), .depth(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the FIFO contents and the vectors of the open window.
   logic [DW-1:0] mq  [$];
   logic [DW-1:0] win [$];
   logic          m_ovf = 1'b0;

   typedef struct {
      logic          r;
      logic          v;
      logic [DW-1:0] d;
      logic          rdy;
      logic          ev;
      logic [DW-1:0] ed;
      int            ec;
      logic          eo;
   } vec_t;

   vec_t tbl [$];

   function automatic logic [DW-1:0] chv(input int ch, input int val);
      logic [DW-1:0] r;
      r = '0;
      r[W*ch +: W] = W'(val);
      return r;
   endfunction

   function automatic vec_t mk(input logic r, input logic v, input logic [DW-1:0] d, input logic rdy,
                               input logic ev, input logic [DW-1:0] ed, input int ec, input logic eo);
      vec_t t;
      t.r = r; t.v = v; t.d = d; t.rdy = rdy;
      t.ev = ev; t.ed = ed; t.ec = ec; t.eo = eo;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic v, input logic [DW-1:0] d, input logic rdy);
      logic          do_pop;
      logic          do_push;
      logic [DW-1:0] pv;
      if (!r) begin
         mq.delete();
         win.delete();
         m_ovf = 1'b0;
         return;
      end
      do_pop  = (mq.size() != 0) && rdy;
      do_push = 1'b0;
      pv      = '0;
      if (v) begin
         win.push_back(d);
         if (win.size() == POOL) begin
            for (int c = 0; c < CH; c++) begin
               int m;
               m = 0;
               foreach (win[k]) if (int'(win[k][W*c +: W]) > m) m = int'(win[k][W*c +: W]);
               pv[W*c +: W] = W'(m);
            end
            do_push = 1'b1;
            win.delete();
         end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         if (mq.size() < DEPTH) mq.push_back(pv);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic rdy);
      logic [DW-1:0] head;
      rst          = r;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.out_ready = rdy;
      @(posedge clk);
      model_update(r, v, d, rdy);
      #1;
      head = (mq.size() != 0) ? mq[0] : '0;
      check("out_valid",  64'(bus.out_valid),  64'(mq.size() != 0));
      check("out_data",   64'(bus.out_data),   64'(head));
      check("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
      check("overflow",   64'(bus.overflow),   64'(m_ovf));
   endtask

   initial begin
      logic [DW-1:0] a1, b1, a2, b2, exp_head;
      int            wrap_exp [4];

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Directed vector table: basic pooling, per-channel max with pop, overflow.
      tbl.push_back(mk(0, 0, '0, 0, 0, '0, 0, 0));
      tbl.push_back(mk(1, 1, chv(0, 3), 0, 0, '0, 0, 0));
      tbl.push_back(mk(1, 1, chv(0, 7), 0, 1, chv(0, 7), 1, 0));
      tbl.push_back(mk(1, 1, chv(9, 15) | chv(4, 1), 1, 0, '0, 0, 0));
      tbl.push_back(mk(1, 1, chv(9, 2) | chv(4, 9), 1, 1, chv(9, 15) | chv(4, 9), 1, 0));
      tbl.push_back(mk(1, 0, '0, 1, 0, '0, 0, 0));
      for (int k = 1; k <= 10; k++)
         tbl.push_back(mk(1, 1, chv(0, k), 0, k >= 2, (k >= 2) ? chv(0, 2) : '0,
                          (k / 2 > 4) ? 4 : k / 2, k >= 10));

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rdy);
         check($sformatf("tbl%0d_valid", i), 64'(bus.out_valid),  64'(tbl[i].ev));
         check($sformatf("tbl%0d_data", i),  64'(bus.out_data),   64'(tbl[i].ed));
         check($sformatf("tbl%0d_count", i), 64'(bus.fifo_count), 64'(tbl[i].ec));
         check($sformatf("tbl%0d_ovf", i),   64'(bus.overflow),   64'(tbl[i].eo));
      end

      // Full FIFO with simultaneous push and pop, then drain across pointer wrap.
      step(0, 0, '0, 0);
      for (int k = 1; k <= 8; k++) step(1, 1, chv(0, k), 0);
      check("full_count", 64'(bus.fifo_count), 64'(4));
      step(1, 1, chv(0, 9), 0);
      step(1, 1, chv(0, 13), 1);
      check("pushpop_count", 64'(bus.fifo_count), 64'(4));
      check("pushpop_ovf",   64'(bus.overflow),   64'(0));
      wrap_exp = '{4, 6, 8, 13};
      for (int j = 0; j < 4; j++) begin
         check($sformatf("wrap_pop%0d", j), 64'(bus.out_data), 64'(chv(0, wrap_exp[j])));
         step(1, 0, '0, 1);
      end
      step(1, 1, chv(0, 3), 0);
      step(1, 1, chv(0, 5), 0);
      check("wrap_pop4", 64'(bus.out_data), 64'(chv(0, 5)));
      step(1, 0, '0, 1);
      check("drained_count", 64'(bus.fifo_count), 64'(0));

      // Reset in the middle of a window throws the partial window away.
      step(1, 1, chv(0, 12), 0);
      step(0, 0, '0, 0);
      step(1, 1, chv(0, 5), 0);
      step(1, 1, chv(0, 4), 0);
      check("rst_mid_data",  64'(bus.out_data),   64'(chv(0, 5)));
      check("rst_mid_count", 64'(bus.fifo_count), 64'(1));
      step(1, 0, '0, 1);

      // Gapped input: 17 idle cycles between every in_valid pulse.
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      foreach (a1[bit_i]) ;
      step(1, 1, a1, 0);
      for (int g = 0; g < 17; g++) step(1, 0, '0, 0);
      step(1, 1, b1, 0);
      for (int g = 0; g < 17; g++) step(1, 0, '0, 0);
      step(1, 1, a2, 0);
      for (int g = 0; g < 17; g++) step(1, 0, '0, 0);
      step(1, 1, b2, 0);
      for (int c = 0; c < CH; c++)
         exp_head[W*c +: W] = (a1[W*c +: W] > b1[W*c +: W]) ? a1[W*c +: W] : b1[W*c +: W];
      check("gap_count", 64'(bus.fifo_count), 64'(2));
      check("gap_head",  64'(bus.out_data),   64'(exp_head));

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 800; n++)
         step($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1,
              DW'({$urandom, $urandom}), $urandom_range(0, 2) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
